// File: rtl/vga_blank_arbiter.sv
// Purpose : round-robin arbiter that shares the tile/colour memory write port during vertical blanking only.
// Latency : req in an open window -> registered grant on the next clock; exactly one dead cycle between owners.
// Backpressure: requests outside the window or over the per-frame budget simply wait; a grant is revoked when the window closes.
//
// Ports:
//   clk          pixel clock
//   reset        asynchronous, active-high reset
//   cnt_h/cnt_v  frame position from the VGA controller
//   req          per-requester level request, held high for the whole transaction
//   grant        one-hot registered grant
//   grant_id     index of the granted requester (meaningful while grant != 0)
//   window_open  registered blanking-window flag (lags the counters by one cycle)
//   preempt      one-cycle pulse when a grant is cut by the window closing
//   frame_tick   one-cycle pulse after cnt_v == 0 && cnt_h == 0
//   grants_used  grants issued in the current frame, saturating at MAX_GRANTS
module vga_blank_arbiter #(
   parameter int N           = 3,
   parameter int H_TOTAL     = 1056,
   parameter int V_VISIBLE   = 600,
   parameter int V_TOTAL     = 628,
   parameter int GUARD_LINES = 2,
   parameter int MAX_GRANTS  = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [10:0]  cnt_h,
   input  logic [9:0]   cnt_v,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant,
   output logic [2:0]   grant_id,
   output logic         window_open,
   output logic         preempt,
   output logic         frame_tick,
   output logic [3:0]   grants_used
);

   // Elaboration-time sanity check on the configuration.
   if (N < 2 || N > 8 || MAX_GRANTS < 1 || MAX_GRANTS > 15 || H_TOTAL < 1 ||
       V_VISIBLE >= V_TOTAL - GUARD_LINES) begin : g_bad_params
      $error("vga_blank_arbiter: illegal parameter set");
   end

   localparam logic [9:0] V_LO  = 10'(V_VISIBLE);
   localparam logic [9:0] V_HI  = 10'(V_TOTAL - GUARD_LINES);
   localparam logic [3:0] MAX_G = 4'(MAX_GRANTS);
   localparam logic [3:0] N_W   = 4'(N);
   localparam logic [2:0] LAST  = 3'(N - 1);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t       state, state_nxt;
   logic [2:0]   ptr, ptr_nxt;
   logic [N-1:0] grant_nxt;
   logic [2:0]   grant_id_nxt;
   logic         preempt_nxt;
   logic         issue;

   logic         win_c;
   logic         frame_start;
   logic         found;
   logic [2:0]   pick;
   logic [3:0]   idx;

   assign win_c       = (cnt_v >= V_LO) && (cnt_v < V_HI);
   assign frame_start = (cnt_v == 10'd0) && (cnt_h == 11'd0);

   // Round-robin search: first live request at or after ptr, wrapping at N.
   always_comb begin
      found = 1'b0;
      pick  = ptr;
      idx   = 4'd0;
      for (int i = 0; i < N; i++) begin
         idx = 4'(ptr) + 4'(i);
         if (idx >= N_W) idx = idx - N_W;
         if (!found && req[idx[2:0]]) begin
            found = 1'b1;
            pick  = idx[2:0];
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant;
      grant_id_nxt = grant_id;
      preempt_nxt  = 1'b0;
      issue        = 1'b0;
      ptr_nxt      = ptr;
      case (state)
         // GAP is the single dead cycle on the memory mux (grant already 0).
         // It arbitrates like IDLE so the next owner follows right after it.
         IDLE, GAP: begin
            state_nxt = IDLE;
            if (win_c && found && (grants_used < MAX_G)) begin
               issue           = 1'b1;
               grant_nxt       = '0;
               grant_nxt[pick] = 1'b1;
               grant_id_nxt    = pick;
               ptr_nxt         = (pick == LAST) ? 3'd0 : pick + 3'd1;
               state_nxt       = GRANT;
            end
         end
         GRANT: begin
            // A release wins over a simultaneous window close: no preempt pulse.
            if (!req[grant_id]) begin
               grant_nxt = '0;
               state_nxt = GAP;
            end else if (!win_c) begin
               grant_nxt   = '0;
               preempt_nxt = 1'b1;
               state_nxt   = GAP;
            end
         end
         default: begin
            grant_nxt = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         ptr         <= 3'd0;
         grant       <= '0;
         grant_id    <= 3'd0;
         preempt     <= 1'b0;
         window_open <= 1'b0;
         frame_tick  <= 1'b0;
         grants_used <= 4'd0;
      end else begin
         state       <= state_nxt;
         ptr         <= ptr_nxt;
         grant       <= grant_nxt;
         grant_id    <= grant_id_nxt;
         preempt     <= preempt_nxt;
         window_open <= win_c;
         frame_tick  <= frame_start;
         // Frame start clears the budget; a grant issued in that same cycle
         // still counts against the new frame.
         if (frame_start)
            grants_used <= issue ? 4'd1 : 4'd0;
         else if (issue)
            grants_used <= grants_used + 4'd1;
      end
   end

endmodule

// File: tb/tb_vga_blank_arbiter.sv
// Purpose : self-checking bench for vga_blank_arbiter, directed scenarios plus randomized requests.
// Latency : outputs compared 1 time unit after each rising edge against a frame-level reference model.
// Backpressure: requesters hold req for a random number of cycles once granted and toggle freely otherwise.
module tb_vga_blank_arbiter;

   localparam int N     = 3;
   localparam int VVIS  = 600;
   localparam int VTOT  = 628;
   localparam int GUARD = 2;
   localparam int MAXG  = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic [10:0]  cnt_h;
   logic [9:0]   cnt_v;
   logic [N-1:0] req;
   logic [N-1:0] grant;
   logic [2:0]   grant_id;
   logic         window_open;
   logic         preempt;
   logic         frame_tick;
   logic [3:0]   grants_used;

   vga_blank_arbiter #(
      .N(N), .H_TOTAL(1056), .V_VISIBLE(VVIS), .V_TOTAL(VTOT),
      .GUARD_LINES(GUARD), .MAX_GRANTS(MAXG)
   ) dut (
      .clk(clk), .reset(reset), .cnt_h(cnt_h), .cnt_v(cnt_v), .req(req),
      .grant(grant), .grant_id(grant_id), .window_open(window_open),
      .preempt(preempt), .frame_tick(frame_tick), .grants_used(grants_used)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: who owns the port, whose turn is next, how many grants this frame.
   int m_owner;
   int m_rr;
   int m_used;
   bit m_pre;
   bit m_tick;
   bit m_win;

   task automatic model_reset();
      m_owner = -1;
      m_rr    = 0;
      m_used  = 0;
      m_pre   = 0;
      m_tick  = 0;
      m_win   = 0;
   endtask

   task automatic model_step();
      bit win;
      bit fs;
      bit issued;
      int c;
      win    = (int'(cnt_v) >= VVIS) && (int'(cnt_v) < VTOT - GUARD);
      fs     = (cnt_v == 0) && (cnt_h == 0);
      issued = 0;
      m_pre  = 0;
      if (m_owner >= 0) begin
         if (!req[m_owner]) m_owner = -1;
         else if (!win) begin
            m_owner = -1;
            m_pre   = 1;
         end
      end else if (win && req != 0 && m_used < MAXG) begin
         for (int k = 0; k < N; k++) begin
            c = (m_rr + k) % N;
            if (!issued && req[c]) begin
               m_owner = c;
               m_rr    = (c + 1) % N;
               issued  = 1;
            end
         end
         if (issued) m_used++;
      end
      if (fs) m_used = issued ? 1 : 0;
      m_win  = win;
      m_tick = fs;
   endtask

   // One clock: model advances on the same edge, outputs compared 1 unit later.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("grant", 32'(grant), (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
      if (m_owner >= 0) check("grant_id", 32'(grant_id), 32'(m_owner));
      check("onehot", 32'($countones(grant) <= 1), 32'd1);
      check("window_open", 32'(window_open), 32'(m_win));
      check("preempt", 32'(preempt), 32'(m_pre));
      check("frame_tick", 32'(frame_tick), 32'(m_tick));
      check("grants_used", 32'(grants_used), 32'(m_used));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      cnt_h = '0;
      cnt_v = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_window", 32'(window_open), 32'd0);
      check("rst_preempt", 32'(preempt), 32'd0);
      check("rst_tick", 32'(frame_tick), 32'd0);
      check("rst_used", 32'(grants_used), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   int           nseq;
   logic [N-1:0] seq [4];
   logic [N-1:0] prev;
   int           held;
   int           zeros;
   int           hold [N];
   int           prev_owner;

   initial begin
      model_reset();

      // Request outside the window waits; first blanking line grants next cycle.
      do_reset();
      req   = 3'b001;
      cnt_v = 10'd100;
      repeat (3) tick();
      check("t1_no_grant", 32'(grant), 32'd0);
      cnt_v = 10'd600;
      cnt_h = 11'd0;
      tick();
      check("t1_grant", 32'(grant), 32'd1);
      check("t1_grant_id", 32'(grant_id), 32'd0);
      check("t1_window", 32'(window_open), 32'd1);

      // Round robin with 5-cycle transactions, then budget exhaustion.
      do_reset();
      cnt_v = 10'd600;
      req   = 3'b111;
      nseq  = 0;
      prev  = '0;
      held  = 0;
      zeros = 0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         tick();
         if (grant != 0 && prev == 0) begin
            if (nseq < 4) begin
               seq[nseq] = grant;
               check("t2_used", 32'(grants_used), 32'(nseq + 1));
               if (nseq > 0) check("t2_dead_cycles", 32'(zeros), 32'd1);
            end
            nseq++;
            held  = 0;
            zeros = 0;
         end
         if (grant == 0) zeros++;
         prev  = grant;
         req   = 3'b111;
         if (grant != 0) begin
            held++;
            if (held == 5) req = 3'b111 & ~grant;
         end
         cnt_h = cnt_h + 11'd1;
      end
      check("t2_count", 32'(nseq), 32'd4);
      check("t2_seq0", 32'(seq[0]), 32'b001);
      check("t2_seq1", 32'(seq[1]), 32'b010);
      check("t2_seq2", 32'(seq[2]), 32'b100);
      check("t2_seq3", 32'(seq[3]), 32'b001);
      check("t3_budget_hold", 32'(grant), 32'd0);
      check("t3_budget_used", 32'(grants_used), 32'd4);
      cnt_v = 10'd0;
      cnt_h = 11'd0;
      tick();
      check("t3_frame_tick", 32'(frame_tick), 32'd1);
      check("t3_used_clear", 32'(grants_used), 32'd0);
      cnt_h = 11'd1;
      cnt_v = 10'd100;
      repeat (3) tick();
      check("t3_wait_window", 32'(grant), 32'd0);
      cnt_v = 10'd600;
      cnt_h = 11'd0;
      tick();
      check("t3_next_grant", 32'(grant), 32'b010);

      // Window closes under an active grant: preempt pulse.
      do_reset();
      req   = 3'b010;
      cnt_v = 10'd600;
      tick();
      check("t4_grant", 32'(grant), 32'b010);
      cnt_v = 10'd625;
      repeat (3) tick();
      cnt_v = 10'd626;
      cnt_h = 11'd0;
      tick();
      check("t4_revoked", 32'(grant), 32'd0);
      check("t4_preempt", 32'(preempt), 32'd1);
      check("t4_window", 32'(window_open), 32'd0);
      tick();
      check("t4_single_pulse", 32'(preempt), 32'd0);

      // Release in the same cycle as window close: no preempt.
      do_reset();
      req   = 3'b001;
      cnt_v = 10'd600;
      tick();
      cnt_v = 10'd625;
      tick();
      check("t5_grant", 32'(grant), 32'b001);
      cnt_v = 10'd626;
      req   = 3'b000;
      tick();
      check("t5_released", 32'(grant), 32'd0);
      check("t5_no_preempt", 32'(preempt), 32'd0);

      // Asynchronous reset in the middle of a grant.
      do_reset();
      req   = 3'b111;
      cnt_v = 10'd600;
      repeat (4) tick();
      #2;
      reset = 1'b1;
      #1;
      check("t6_async_grant", 32'(grant), 32'd0);
      check("t6_async_used", 32'(grants_used), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      tick();
      check("t6_ptr_restart", 32'(grant), 32'b001);

      // Randomized requests over compressed frames (lines 2..595 skipped).
      do_reset();
      for (int i = 0; i < N; i++) hold[i] = 0;
      prev_owner = -1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (i == m_owner) begin
               if (hold[i] == 0) req[i] = 1'b0;
               else hold[i]--;
            end else if ($urandom_range(0, 3) == 0) begin
               req[i] = ~req[i];
            end
         end
         tick();
         if (m_owner >= 0 && m_owner != prev_owner) hold[m_owner] = $urandom_range(1, 10);
         prev_owner = m_owner;
         if (cnt_h == 11'd3) begin
            cnt_h = 11'd0;
            if (cnt_v == 10'd1)        cnt_v = 10'd596;
            else if (cnt_v == 10'd627) cnt_v = 10'd0;
            else                       cnt_v = cnt_v + 10'd1;
         end else begin
            cnt_h = cnt_h + 11'd1;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
